id_exe_skid_reg: RTL



---
 rtl/arm_pipe_pkg.sv | 70 +++++++
 rtl/id_pipe_slot.sv | 90 +++++++++
 rtl/id_exe_skid_reg.sv | 107 ++++++++++
 3 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared decode->execute payload layout: field widths, packed struct and
// bit offsets for width-parameterised flat payload vectors.
package arm_pipe_pkg;

    localparam int unsigned EXEC_CMD_W = 4;
    localparam int unsigned SHIFT_OP_W = 12;
    localparam int unsigned SIMM_W     = 24;
    localparam int unsigned STATUS_W   = 4;
    localparam int unsigned CTRL_W     = 5;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_PC_W    = 32;
    localparam int unsigned DEF_RADDR_W = 4;

    // Flat payload width for any register/pc/address width combination.
    function automatic int unsigned pl_width(input int unsigned data_w,
                                             input int unsigned pc_w,
                                             input int unsigned raddr_w);
        return CTRL_W + EXEC_CMD_W + pc_w + 3 * data_w + SHIFT_OP_W + SIMM_W
               + 3 * raddr_w + 2 + STATUS_W;
    endfunction

    localparam int unsigned PL_W = pl_width(DEF_DATA_W, DEF_PC_W, DEF_RADDR_W);

    // LSB offsets of the fields the writeback snoop touches.
    localparam int unsigned OFF_USE_RM = STATUS_W;
    localparam int unsigned OFF_USE_RN = STATUS_W + 1;
    localparam int unsigned OFF_SRC2   = STATUS_W + 2;

    function automatic int unsigned off_src1(input int unsigned raddr_w);
        return OFF_SRC2 + raddr_w;
    endfunction

    function automatic int unsigned off_val_rm(input int unsigned data_w,
                                               input int unsigned raddr_w);
        return OFF_SRC2 + 3 * raddr_w + SIMM_W + SHIFT_OP_W + data_w;
    endfunction

    function automatic int unsigned off_val_rn(input int unsigned data_w,
                                               input int unsigned raddr_w);
        return off_val_rm(data_w, raddr_w) + data_w;
    endfunction

    typedef struct packed {
        logic wb_en;
        logic mem_r;
        logic mem_w;
        logic b;
        logic s;
    } ctrl_t;

    // Default-width payload; first member is the MSB of the flat vector.
    typedef struct packed {
        ctrl_t                  ctrl;
        logic [EXEC_CMD_W-1:0]  exec_cmd;
        logic [DEF_PC_W-1:0]    pc;
        logic [DEF_DATA_W-1:0]  val_rn;
        logic [DEF_DATA_W-1:0]  val_rm;
        logic [DEF_DATA_W-1:0]  imm;
        logic [SHIFT_OP_W-1:0]  shift_op;
        logic [SIMM_W-1:0]      simm24;
        logic [DEF_RADDR_W-1:0] dest;
        logic [DEF_RADDR_W-1:0] src1;
        logic [DEF_RADDR_W-1:0] src2;
        logic                   use_rn;
        logic                   use_rm;
        logic [STATUS_W-1:0]    status;
    } pipe_pl_t;

endpackage

// File: rtl/id_pipe_slot.sv
// One buffer slot: valid bit, payload register and writeback snoop.
// Snoop logic present only when ID_PIPE_WB_SNOOP_EN is defined.
module id_pipe_slot
    import arm_pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned PC_W    = DEF_PC_W,
    parameter int unsigned RADDR_W = DEF_RADDR_W,
    localparam int unsigned SLOT_W = pl_width(DATA_W, PC_W, RADDR_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic               clr_i,
    input  logic [SLOT_W-1:0]  load_pl_i,
    input  logic               wb_en_i,
    input  logic [RADDR_W-1:0] wb_dest_i,
    input  logic [DATA_W-1:0]  wb_result_i,
    output logic               valid_o,
    output logic [SLOT_W-1:0]  pl_o
);

    logic              valid_q, valid_d;
    logic [SLOT_W-1:0] pl_q, pl_d;
    logic [SLOT_W-1:0] load_snp, held_snp;

`ifdef ID_PIPE_WB_SNOOP_EN
    localparam int unsigned OFF_SRC1   = off_src1(RADDR_W);
    localparam int unsigned OFF_VAL_RM = off_val_rm(DATA_W, RADDR_W);
    localparam int unsigned OFF_VAL_RN = off_val_rn(DATA_W, RADDR_W);

    // Replace source operands that match the register being written back.
    function automatic logic [SLOT_W-1:0] snoop(input logic [SLOT_W-1:0]  pl,
                                                input logic               en,
                                                input logic [RADDR_W-1:0] dest,
                                                input logic [DATA_W-1:0]  res);
        logic [SLOT_W-1:0] r;
        r = pl;
        if (en && pl[OFF_USE_RN] && (pl[OFF_SRC1 +: RADDR_W] == dest)) begin
            r[OFF_VAL_RN +: DATA_W] = res;
        end
        if (en && pl[OFF_USE_RM] && (pl[OFF_SRC2 +: RADDR_W] == dest)) begin
            r[OFF_VAL_RM +: DATA_W] = res;
        end
        return r;
    endfunction

    assign load_snp = snoop(load_pl_i, wb_en_i, wb_dest_i, wb_result_i);
    assign held_snp = snoop(pl_q, wb_en_i, wb_dest_i, wb_result_i);
`else
    logic wb_unused;
    assign wb_unused = ^{wb_en_i, wb_dest_i, wb_result_i};
    assign load_snp  = load_pl_i;
    assign held_snp  = pl_q;
`endif

    // Flush clears valid only; payload bits are frozen during flush.
    always_comb begin
        valid_d = valid_q;
        pl_d    = pl_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pl_d    = load_snp;
        end else begin
            if (clr_i) begin
                valid_d = 1'b0;
            end
            if (valid_q) begin
                pl_d = held_snp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pl_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pl_q    <= pl_d;
        end
    end

    assign valid_o = valid_q;
    assign pl_o    = pl_q;

endmodule

// File: rtl/id_exe_skid_reg.sv
// ID->EXE two-entry skid buffer (head + skid slot) with optional writeback
// snoop of held operands, enabled by defining ID_PIPE_WB_SNOOP_EN.
module id_exe_skid_reg
    import arm_pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned PC_W    = DEF_PC_W,
    parameter int unsigned RADDR_W = DEF_RADDR_W,
    localparam int unsigned PAY_W  = pl_width(DATA_W, PC_W, RADDR_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               hazard,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PAY_W-1:0]   in_pl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PAY_W-1:0]   out_pl,
    input  logic               wb_en,
    input  logic [RADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0]  wb_result,
    output logic [1:0]         occ
);

    logic             head_v, skid_v;
    logic [PAY_W-1:0] head_pl, skid_pl, head_load_pl;
    logic             push, pop;
    logic             head_from_skid, head_load, head_clr;
    logic             skid_load, skid_clr;
    logic [1:0]       occ_q, occ_d;

    assign in_ready = !skid_v && !hazard && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = head_v && out_ready;

    // Head refills from skid on pop; otherwise takes the incoming payload
    // when empty or being popped in the same cycle.
    assign head_from_skid = pop && skid_v;
    assign head_load      = head_from_skid || (push && (!head_v || pop));
    assign head_clr       = pop && !skid_v;
    assign head_load_pl   = head_from_skid ? skid_pl : in_pl;
    assign skid_load      = push && head_v && !pop;
    assign skid_clr       = pop;

    id_pipe_slot #(
        .DATA_W  (DATA_W),
        .PC_W    (PC_W),
        .RADDR_W (RADDR_W)
    ) u_head (
        .clk         (clk),
        .rst_n       (rst),
        .flush_i     (flush),
        .load_i      (head_load),
        .clr_i       (head_clr),
        .load_pl_i   (head_load_pl),
        .wb_en_i     (wb_en),
        .wb_dest_i   (wb_dest),
        .wb_result_i (wb_result),
        .valid_o     (head_v),
        .pl_o        (head_pl)
    );

    id_pipe_slot #(
        .DATA_W  (DATA_W),
        .PC_W    (PC_W),
        .RADDR_W (RADDR_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst),
        .flush_i     (flush),
        .load_i      (skid_load),
        .clr_i       (skid_clr),
        .load_pl_i   (in_pl),
        .wb_en_i     (wb_en),
        .wb_dest_i   (wb_dest),
        .wb_result_i (wb_result),
        .valid_o     (skid_v),
        .pl_o        (skid_pl)
    );

    // Occupancy tracks push/pop; push is impossible at 2, pop at 0.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = 2'd0;
        end else if (push && !pop) begin
            occ_d = occ_q + 2'd1;
        end else if (pop && !push) begin
            occ_d = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign out_valid = head_v;
    assign out_pl    = head_pl;
    assign occ       = occ_q;

endmodule
